// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM slave port among NB_MASTERS masters.
// Ports: clk_i/rst_ni; m_* master side (req/gnt/r_valid); s_* slave side.
// Optional: define TCDM_ARB_ERR_EN to reject out-of-range addresses locally.
module tcdm_rr_arbiter #(
  parameter int unsigned NB_MASTERS     = 4,
  parameter logic [31:0] ADDR_START     = 32'h1C000000,
  parameter logic [31:0] ADDR_END       = 32'h1C080000,
  parameter logic [31:0] ERROR_RESPONSE = 32'hBADACCE5
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NB_MASTERS-1:0]            m_req_i,
  input  logic [NB_MASTERS-1:0][31:0]      m_add_i,
  input  logic [NB_MASTERS-1:0]            m_wen_i,
  input  logic [NB_MASTERS-1:0][31:0]      m_wdata_i,
  input  logic [NB_MASTERS-1:0][3:0]       m_be_i,
  output logic [NB_MASTERS-1:0]            m_gnt_o,
  output logic [NB_MASTERS-1:0]            m_r_valid_o,
  output logic [31:0]                      m_r_rdata_o,
  output logic                             m_r_opc_o,
  output logic                             s_req_o,
  output logic [31:0]                      s_add_o,
  output logic                             s_wen_o,
  output logic [31:0]                      s_wdata_o,
  output logic [3:0]                       s_be_o,
  input  logic                             s_gnt_i,
  input  logic                             s_r_valid_i,
  input  logic [31:0]                      s_r_rdata_i,
  input  logic                             s_r_opc_i
);

  localparam int unsigned IW =
    (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

  logic [IW-1:0] rr_q;
  logic [IW-1:0] resp_idx_q;
  logic          resp_pend_q;
  logic [IW-1:0] win;
  logic          req_any;
  logic          err;
  logic          hs;

  assign req_any = |m_req_i;

  // Scan from rr_q upward with wrap; first requester wins.
  always_comb begin
    int unsigned idx;
    logic        found;
    win   = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NB_MASTERS; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NB_MASTERS) idx = idx - NB_MASTERS;
      if (!found && m_req_i[idx]) begin
        win   = idx[IW-1:0];
        found = 1'b1;
      end
    end
  end

`ifdef TCDM_ARB_ERR_EN
  logic err_q;

  assign err = req_any &
    ((m_add_i[win] < ADDR_START) ||
     (m_add_i[win] >= ADDR_END));
`else
  logic unused_params;

  assign err = 1'b0;
  assign unused_params =
    ^{ADDR_START, ADDR_END, ERROR_RESPONSE};
`endif

  assign s_req_o   = req_any & ~err;
  assign s_add_o   = m_add_i[win];
  assign s_wen_o   = m_wen_i[win];
  assign s_wdata_o = m_wdata_i[win];
  assign s_be_o    = m_be_i[win];

  // Rejected accesses complete locally without the slave.
  assign hs = (s_req_o & s_gnt_i) | err;

  always_comb begin
    m_gnt_o = '0;
    if (req_any) m_gnt_o[win] = s_gnt_i | err;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      resp_idx_q  <= '0;
      resp_pend_q <= 1'b0;
    end else begin
      resp_pend_q <= hs;
      if (hs) begin
        resp_idx_q <= win;
        rr_q <= (win == IW'(NB_MASTERS - 1)) ?
                '0 : win + IW'(1);
      end
    end
  end

`ifdef TCDM_ARB_ERR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err;
  end

  always_comb begin
    m_r_valid_o = '0;
    if (resp_pend_q & (err_q | s_r_valid_i))
      m_r_valid_o[resp_idx_q] = 1'b1;
    m_r_rdata_o = err_q ? ERROR_RESPONSE : s_r_rdata_i;
    m_r_opc_o   = err_q ? 1'b1 : s_r_opc_i;
  end
`else
  always_comb begin
    m_r_valid_o = '0;
    if (resp_pend_q & s_r_valid_i)
      m_r_valid_o[resp_idx_q] = 1'b1;
    m_r_rdata_o = s_r_rdata_i;
    m_r_opc_o   = s_r_opc_i;
  end
`endif

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Testbench for tcdm_rr_arbiter: directed stimulus, queued expectations.
// Ports driven by a behavioural 1-cycle slave; define TCDM_ARB_ERR_EN for error tests.
module tb_tcdm_rr_arbiter;
  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst_ni;
  logic [N-1:0]        m_req_i;
  logic [N-1:0][31:0]  m_add_i;
  logic [N-1:0]        m_wen_i;
  logic [N-1:0][31:0]  m_wdata_i;
  logic [N-1:0][3:0]   m_be_i;
  logic [N-1:0]        m_gnt_o;
  logic [N-1:0]        m_r_valid_o;
  logic [31:0]         m_r_rdata_o;
  logic                m_r_opc_o;
  logic                s_req_o;
  logic [31:0]         s_add_o;
  logic                s_wen_o;
  logic [31:0]         s_wdata_o;
  logic [3:0]          s_be_o;
  logic                s_gnt_i;
  logic                s_r_valid_i = 1'b0;
  logic [31:0]         s_r_rdata_i = '0;
  logic                s_r_opc_i   = 1'b0;

  logic [31:0] rd_val = '0;
  logic        rd_opc = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        opc;
    int          due;
  } exp_t;

  exp_t q[$];

  tcdm_rr_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .m_req_i     (m_req_i),
    .m_add_i     (m_add_i),
    .m_wen_i     (m_wen_i),
    .m_wdata_i   (m_wdata_i),
    .m_be_i      (m_be_i),
    .m_gnt_o     (m_gnt_o),
    .m_r_valid_o (m_r_valid_o),
    .m_r_rdata_o (m_r_rdata_o),
    .m_r_opc_o   (m_r_opc_o),
    .s_req_o     (s_req_o),
    .s_add_o     (s_add_o),
    .s_wen_o     (s_wen_o),
    .s_wdata_o   (s_wdata_o),
    .s_be_o      (s_be_o),
    .s_gnt_i     (s_gnt_i),
    .s_r_valid_i (s_r_valid_i),
    .s_r_rdata_i (s_r_rdata_i),
    .s_r_opc_i   (s_r_opc_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: answers exactly one cycle after each handshake.
  always @(posedge clk) begin
    s_r_valid_i <= s_req_o & s_gnt_i;
    s_r_rdata_i <= (s_req_o & s_gnt_i) ? rd_val : 32'h0;
    s_r_opc_i   <= (s_req_o & s_gnt_i) ? rd_opc : 1'b0;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per presented response.
  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL resp_missing: got none expected idx %0d at cycle %0d",
               q[0].idx, q[0].due);
      void'(q.pop_front());
    end
    if (m_r_valid_o != '0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got %b expected 0000 (cycle %0d)",
                 m_r_valid_o, cyc);
      end else begin
        e = q.pop_front();
        chk("r_valid", 32'(m_r_valid_o), 32'(1) << e.idx);
        chk("r_rdata", m_r_rdata_o, e.rdata);
        chk("r_opc", 32'(m_r_opc_o), 32'(e.opc));
        chk("r_cycle", cyc, e.due);
      end
    end
  end

  // One cycle: drive, check grant side, queue the expected response.
  task automatic step(input logic [3:0]  req,
                      input logic        g,
                      input int          w,
                      input logic [3:0]  eg,
                      input logic        esr,
                      input logic        push,
                      input logic [31:0] rv,
                      input logic        ro);
    exp_t e;
    m_req_i = req;
    s_gnt_i = g;
    rd_val  = rv;
    rd_opc  = ro;
    @(negedge clk);
    chk("gnt", 32'(m_gnt_o), 32'(eg));
    chk("s_req", 32'(s_req_o), 32'(esr));
    if (esr) begin
      chk("s_add", s_add_o, m_add_i[w]);
      chk("s_wdata", s_wdata_o, m_wdata_i[w]);
    end
    if (eg != 4'b0 && push) begin
      e.idx   = w;
      e.rdata = esr ? rv : 32'hBADACCE5;
      e.opc   = esr ? ro : 1'b1;
      e.due   = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(4'b0, 1'b1, 0, 4'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    m_req_i = '0;
    s_gnt_i = 1'b0;
    rst_ni  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_add_i[i]   = 32'h1C000000 + 32'(i) * 32'h100;
      m_wdata_i[i] = 32'hD0000000 + 32'(i);
      m_be_i[i]    = 4'hF;
    end
    m_wen_i = '1;
    m_req_i = '0;
    s_gnt_i = 1'b0;
    rst_ni  = 1'b0;

    @(negedge clk);
    chk("rst_gnt", 32'(m_gnt_o), 32'h0);
    chk("rst_rvalid", 32'(m_r_valid_o), 32'h0);
    chk("rst_rdata", m_r_rdata_o, 32'h0);
    chk("rst_opc", 32'(m_r_opc_o), 32'h0);
    chk("rst_sreq", 32'(s_req_o), 32'h0);
    @(posedge clk);
    #1 rst_ni = 1'b1;

    // All request, slave stalls 3 cycles, then rotation 0,1,2,3,0.
    repeat (3)
      step(4'hF, 1'b0, 0, 4'b0000, 1'b1, 1'b1, 32'h0, 1'b0);
    step(4'hF, 1'b1, 0, 4'b0001, 1'b1, 1'b1, 32'h11110000, 1'b0);
    step(4'hF, 1'b1, 1, 4'b0010, 1'b1, 1'b1, 32'h11110001, 1'b0);
    step(4'hF, 1'b1, 2, 4'b0100, 1'b1, 1'b1, 32'h11110002, 1'b0);
    step(4'hF, 1'b1, 3, 4'b1000, 1'b1, 1'b1, 32'h11110003, 1'b0);
    step(4'hF, 1'b1, 0, 4'b0001, 1'b1, 1'b1, 32'h11110004, 1'b0);
    idle(1);

    // Masters 0 and 2 alternate.
    do_reset();
    step(4'b0101, 1'b1, 0, 4'b0001, 1'b1, 1'b1, 32'h22220000, 1'b0);
    step(4'b0101, 1'b1, 2, 4'b0100, 1'b1, 1'b1, 32'h22220001, 1'b0);
    step(4'b0101, 1'b1, 0, 4'b0001, 1'b1, 1'b1, 32'h22220002, 1'b0);
    step(4'b0101, 1'b1, 2, 4'b0100, 1'b1, 1'b1, 32'h22220003, 1'b0);
    idle(1);

    // Master 3 read; then master 1 alone, write with slave error.
    m_add_i[3] = 32'h1C000010;
    step(4'b1000, 1'b1, 3, 4'b1000, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0);
    m_wen_i[1] = 1'b0;
    step(4'b0010, 1'b1, 1, 4'b0010, 1'b1, 1'b1, 32'h00000000, 1'b1);
    m_wen_i[1] = 1'b1;
    step(4'b0010, 1'b1, 1, 4'b0010, 1'b1, 1'b1, 32'h33330001, 1'b0);
    step(4'b0010, 1'b1, 1, 4'b0010, 1'b1, 1'b1, 32'h33330002, 1'b0);
    // Master 2 withdraws while stalled; winner recomputed.
    step(4'b1100, 1'b0, 2, 4'b0000, 1'b1, 1'b1, 32'h0, 1'b0);
    step(4'b1000, 1'b1, 3, 4'b1000, 1'b1, 1'b1, 32'h44440000, 1'b0);
    idle(1);

`ifdef TCDM_ARB_ERR_EN
    // Out-of-range read: local grant, error response.
    m_add_i[1] = 32'h1A100000;
    step(4'b0010, 1'b0, 1, 4'b0010, 1'b0, 1'b1, 32'h0, 1'b0);
    // Write at ADDR_END rejected; just below is forwarded.
    m_add_i[0] = 32'h1C080000;
    m_wen_i[0] = 1'b0;
    step(4'b0001, 1'b1, 0, 4'b0001, 1'b0, 1'b1, 32'h0, 1'b0);
    m_add_i[0] = 32'h1C07FFFC;
    step(4'b0001, 1'b1, 0, 4'b0001, 1'b1, 1'b1, 32'h12345678, 1'b0);
    m_add_i[0] = 32'h1C000000;
    m_add_i[1] = 32'h1C000100;
    m_wen_i[0] = 1'b1;
    idle(1);
`endif

    // Reset right after a handshake drops its response.
    step(4'b0010, 1'b1, 1, 4'b0010, 1'b1, 1'b0, 32'h55550000, 1'b0);
    rst_ni  = 1'b0;
    m_req_i = '0;
    s_gnt_i = 1'b0;
    @(negedge clk);
    chk("rst_drop_rvalid", 32'(m_r_valid_o), 32'h0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    step(4'hF, 1'b1, 0, 4'b0001, 1'b1, 1'b1, 32'h66660000, 1'b0);
    idle(2);

    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
